// File: rtl/mips32_prog_loader.sv
// Byte-serial program loader: assembles big-endian words, writes instruction
// memory, and releases the MIPS32 core only after a checksum-verified image.
module mips32_prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       word_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        word_q, word_d;
  logic [7:0]         chk_q, chk_d;
  logic               in_ready_q, in_ready_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               core_run_q, core_run_d;
  logic               load_done_q, load_done_d;
  logic               load_err_q, load_err_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

  logic               accept_c;
  logic [CNT_W-1:0]   n_new_c;

  assign accept_c = in_valid & in_ready_q;
  assign n_new_c  = {n_q[15:8], in_data};

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    chk_d       = chk_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    core_run_d  = core_run_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    word_cnt_d  = word_cnt_q;
    in_ready_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_HDR_HI;
          n_d         = '0;
          byte_cnt_d  = '0;
          word_d      = '0;
          chk_d       = '0;
          word_cnt_d  = '0;
          core_run_d  = 1'b0;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
        end
      end
      S_HDR_HI: begin
        if (accept_c) begin
          n_d     = {in_data, 8'h00};
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept_c) begin
          n_d = n_new_c;
          if (32'(n_new_c) > MAX_WORDS) begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end else if (n_new_c == '0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept_c) begin
          word_d     = {word_q[15:0], in_data};
          chk_d      = chk_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Fourth byte completes the word: strobe it out next cycle
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_W'(BASE_ADDR + 32'(word_cnt_q));
            mem_wdata_d = {word_q, in_data};
            word_cnt_d  = word_cnt_q + 16'd1;
            if (word_cnt_d == n_q) begin
              state_d = S_CHK;
            end
          end
        end
      end
      S_CHK: begin
        if (accept_c) begin
          if (in_data == chk_q) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
            core_run_d  = 1'b1;
          end else begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                 (state_d == S_DATA)   || (state_d == S_CHK);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      chk_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_run_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      chk_q       <= chk_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_run_q  <= core_run_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_run  = core_run_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader: directed and random images
// compared against a queue-based model of the stream format.
module tb_mips32_prog_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MAX_WORDS = 1024;
  localparam int unsigned BASE_ADDR = 0;
  localparam int          TMO       = 40;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_run;
  logic              load_done;
  logic              load_err;
  logic [15:0]       word_cnt;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+31:0] wr_q[$];
  logic [31:0]        words[$];

  mips32_prog_loader #(
    .ADDR_W   (ADDR_W),
    .MAX_WORDS(MAX_WORDS),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .core_run (core_run),
    .load_done(load_done),
    .load_err (load_err),
    .word_cnt (word_cnt)
  );

  always #5 clk1 = ~clk1;

  // Every observed write, sampled mid-cycle
  always @(negedge clk1) begin
    if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_mem_we"},    64'(mem_we),    64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_core_run"},  64'(core_run),  64'd0);
    check({tag, "_load_done"}, 64'(load_done), 64'd0);
    check({tag, "_load_err"},  64'(load_err),  64'd0);
    check({tag, "_word_cnt"},  64'(word_cnt),  64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && t < TMO) begin
      @(posedge clk1); #1;
      t++;
    end
    check("accept_timeout", 64'(t < TMO), 64'd1);
    @(posedge clk1); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Full load of `words`; optional bad checksum and a 5-cycle stall before byte gap_at
  task automatic run_load(input bit bad, input int gap_at, input bit start_in_gap);
    logic [7:0]         bytes[$];
    logic [ADDR_W+31:0] exp_wr[$];
    logic [7:0]         x = 8'h00;
    logic [15:0]        n = 16'(words.size());
    logic [31:0]        w;
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 3; k >= 0; k--) begin
        bytes.push_back(w[8*k +: 8]);
        x = x ^ w[8*k +: 8];
      end
      exp_wr.push_back({ADDR_W'(BASE_ADDR + 32'(i)), w});
    end
    wr_q.delete();
    pulse_start();
    check("start_clr_done", 64'(load_done), 64'd0);
    check("start_clr_err",  64'(load_err),  64'd0);
    check("start_clr_run",  64'(core_run),  64'd0);
    check("start_clr_cnt",  64'(word_cnt),  64'd0);
    check("start_ready",    64'(in_ready),  64'd1);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 5; g++) begin
          start = start_in_gap && (g == 2);
          @(posedge clk1); #1;
        end
        start = 1'b0;
      end
      send_byte(bytes[i]);
      if (i % 4 == 3) begin
        check("we_pulse", 64'(mem_we), 64'd1);
        check("we_addr",  64'(mem_addr), 64'(ADDR_W'(BASE_ADDR + 32'(i / 4))));
        check("we_cnt",   64'(word_cnt), 64'(i / 4 + 1));
      end
    end
    check("pre_chk_done", 64'(load_done), 64'd0);
    check("pre_chk_run",  64'(core_run),  64'd0);
    send_byte(bad ? (x ^ 8'h01) : x);
    check("load_done", 64'(load_done), 64'(!bad));
    check("load_err",  64'(load_err),  64'(bad));
    check("core_run",  64'(core_run),  64'(!bad));
    check("word_cnt",  64'(word_cnt),  64'(n));
    check("ready_end", 64'(in_ready),  64'd0);
    repeat (2) @(posedge clk1);
    #1;
    check("hold_done", 64'(load_done), 64'(!bad));
    check("wr_count",  64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++) begin
      if (i < wr_q.size()) check("wr_entry", 64'(wr_q[i]), 64'(exp_wr[i]));
    end
  endtask

  initial begin
    logic [31:0] w;
    int          n;

    repeat (3) @(posedge clk1);
    #1;
    check_all_zero("reset");
    @(negedge clk1) rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    in_valid = 1'b0;
    check("idle_ready", 64'(in_ready), 64'd0);

    // Single word, then two words good and bad
    words = '{32'hFC000000};
    run_load(1'b0, -1, 1'b0);
    words = '{32'h2801000A, 32'h28020014};
    run_load(1'b0, -1, 1'b0);
    run_load(1'b1, -1, 1'b0);

    // Oversized header
    wr_q.delete();
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h01);
    check("big_err",   64'(load_err),  64'd1);
    check("big_ready", 64'(in_ready),  64'd0);
    check("big_run",   64'(core_run),  64'd0);
    check("big_done",  64'(load_done), 64'd0);
    repeat (3) @(posedge clk1);
    #1;
    check("big_nowr", 64'(wr_q.size()), 64'd0);
    check("big_hold", 64'(load_err), 64'd1);

    // Stall mid-word with an ignored start
    words = '{32'h2801000A, 32'h28020014};
    run_load(1'b0, 2, 1'b1);

    // Reset after first word of an N=3 load
    words = '{$urandom, $urandom, $urandom};
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    w = words[0];
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
    check("rst_w0_we", 64'(mem_we), 64'd1);
    @(posedge clk1); #1;
    wr_q.delete();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    rst_n    = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) @(posedge clk1);
    #1;
    check_all_zero("midrst_hold");
    in_valid = 1'b0;
    @(negedge clk1) rst_n = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    check("midrst_nowr", 64'(wr_q.size()), 64'd0);
    words = '{$urandom};
    run_load(1'b0, -1, 1'b0);

    // Empty image: checksum must be zero
    words.delete();
    run_load(1'b0, -1, 1'b0);
    run_load(1'b1, -1, 1'b0);

    // Random images
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 6));
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load(($urandom % 3) == 0, int'($urandom_range(0, 4 * n - 1)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
- Program loader directly upstream of the two-phase pipelined MIPS32 core.
- Receives a byte-serial program image over a valid/ready stream and assembles big-endian 32-bit instruction words.
- Writes the words into the core's instruction memory through a single write port.
- Holds the core idle until a complete, checksum-verified image is loaded, so the PC=0 / HALTED=0 / TAKEN_BRANCH=0 initialisation is no longer done by hand.

Parameters:
- ADDR_W, 10, memory word-address width.
- MAX_WORDS, 1024, largest accepted word count; must be <= 2**ADDR_W.
- BASE_ADDR, 0, word address of the first instruction written.

Ports:
- clk1  input  1  single clock; only posedge is used.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  32  write data.
- core_run  output  1  high releases the core; low keeps it halted with PC held at 0.
- load_done  output  1  image loaded and verified.
- load_err  output  1  image rejected.
- word_cnt  output  16  words written so far in the current load.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, core_run, load_done, load_err, word_cnt.
  - Internal byte counter, word count N and checksum accumulator cleared.
  - Reset mid-load abandons the load; no further mem_we is issued.
- Byte accept: a byte is taken on a clk1 posedge where in_valid=1 and in_ready=1. in_ready is a registered function of state: 1 in HDR_HI, HDR_LO, DATA and CHK; 0 elsewhere.
- Stream format, in order:
  - N[15:8], then N[7:0].
  - 4*N payload bytes, each word MSB first.
  - One checksum byte equal to the XOR of all payload bytes. The header is excluded.
- State machine:
  - IDLE: start -> HDR_HI; core_run=0.
  - HDR_HI: accept -> latch N[15:8] -> HDR_LO.
  - HDR_LO: accept -> latch N[7:0].
    - N > MAX_WORDS -> ERR.
    - N == 0 -> CHK.
    - Otherwise -> DATA.
  - DATA: accept -> shift byte into the word register and XOR it into the checksum.
    - On the 4th byte of a word, the next cycle has mem_we=1 for exactly one cycle, mem_addr = BASE_ADDR + word_cnt, mem_wdata = assembled word.
    - word_cnt increments in that same cycle.
    - After word N-1 is written -> CHK.
    - in_ready may remain high during the write cycle; a byte arriving then is the first byte of the next word.
  - CHK: accept -> byte == checksum ? DONE : ERR. For N=0 the expected checksum is 0x00.
  - DONE: load_done=1, core_run=1; both held.
  - ERR: load_err=1, core_run=0; both held.
- Start handling:
  - start in DONE or ERR clears load_done, load_err, core_run and word_cnt the next cycle, then enters HDR_HI.
  - start in HDR_HI, HDR_LO, DATA or CHK is ignored.
- Latency: the write strobe comes 1 cycle after the 4th byte is accepted. core_run rises 1 cycle after the checksum byte is accepted.
- in_valid stalls: any gap is tolerated in every receiving state with no timeout; state and partial word are held.
- mem_addr wraps modulo 2**ADDR_W if BASE_ADDR + N exceeds the address space. No error is raised; integrators must size BASE_ADDR accordingly.
- Outside the DATA write cycle, mem_addr and mem_wdata hold their last values and mem_we=0.

Test Plan:
- N=1, bytes 00 01 FC 00 00 00 FC -> one mem_we at addr 0 with data 0xFC000000; word_cnt=1; load_done=1 and core_run=1 one cycle after the checksum byte.
- N=2, bytes 00 02 28 01 00 0A 28 02 00 14 1D -> writes 0x2801000A at addr 0 and 0x28020014 at addr 1; DONE.
- Same N=2 image but checksum byte 0x1C -> both words still written; load_err=1, core_run=0, load_done=0.
- Header 04 01 (N=1025 > MAX_WORDS) -> ERR right after the second header byte; no mem_we; in_ready=0.
- N=2 image with in_valid deasserted for 5 cycles between bytes 2 and 3 of word 0, and start pulsed mid-DATA -> identical writes and DONE; start has no effect.
- Assert rst_n=0 after word 0 of an N=3 load, then rerun a full N=1 load -> all outputs 0 during reset; only the new image's write occurs and the new load completes normally.
